// File: rtl/usb_phy_pkg.sv
// ---------------------------------------------------------------------------
// usb_phy_pkg
//   Shared definitions for the USB 1.1 PHY transmit path.
//   - tx_state_e : transmit scheduler states
//   - obuf_t     : output byte register {valid, sop, eop, data}
//   - PID_*      : handshake packet identifiers
//   - ABORT_BYTE : byte sent to terminate a packet that ran dry
// ---------------------------------------------------------------------------
package usb_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HS,
        ST_DATA,
        ST_DRAIN,
        ST_GAP
    } tx_state_e;

    localparam logic [7:0] PID_ACK    = 8'hD2;
    localparam logic [7:0] PID_NAK    = 8'h5A;
    localparam logic [7:0] PID_STALL  = 8'h1E;
    localparam logic [7:0] ABORT_BYTE = 8'hFF;

    typedef struct packed {
        logic       valid;
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } obuf_t;

    // Build a full byte-register entry.
    function automatic obuf_t obuf_load(input logic       sop,
                                        input logic       eop,
                                        input logic [7:0] data);
        obuf_t o;
        o.valid = 1'b1;
        o.sop   = sop;
        o.eop   = eop;
        o.data  = data;
        return o;
    endfunction

endpackage

// File: rtl/phy_tx_sched.sv
// ---------------------------------------------------------------------------
// phy_tx_sched
//   Transmit packet scheduler in front of the byte-to-bit serializer.
//   Arbitrates between a high-priority single-byte handshake source and a
//   sop/eop framed data source, holds each byte until the serializer takes
//   it, enforces an inter-packet gap and aborts a packet on data underrun.
//
// Parameters
//   IPG_CLKS     : clocks from last-byte transfer to next packet start (>=2)
//
// Ports
//   clk, rst_n   : 48 MHz clock, asynchronous active-low reset
//   hs_req/pid   : handshake request (held until hs_done) and its PID
//   hs_done      : pulse in the cycle the handshake byte is transferred
//   d_valid/sop/eop/data, d_ready : data source byte stream
//   tx_sop/eop/valid/data         : registered byte to the serializer
//   tx_ready     : single-cycle byte request from the serializer
//   busy         : scheduler not idle
//   err_underrun : pulse, serializer asked for a byte with none available
//   err_framing  : pulse, non-sop data byte discarded while idle
// ---------------------------------------------------------------------------
module phy_tx_sched
    import usb_phy_pkg::*;
#(
    parameter int unsigned IPG_CLKS = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hs_req,
    input  logic [7:0] hs_pid,
    output logic       hs_done,
    input  logic       d_valid,
    input  logic       d_sop,
    input  logic       d_eop,
    input  logic [7:0] d_data,
    output logic       d_ready,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err_underrun,
    output logic       err_framing
);

    localparam int unsigned      CNT_W    = $clog2(IPG_CLKS);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(IPG_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_ONE  = CNT_W'(1);

    tx_state_e        state_q;
    obuf_t            obuf_q;
    logic [CNT_W-1:0] gap_cnt_q;
    logic             drain_eop_q;     // d_eop already consumed while draining
    logic             err_underrun_q;
    logic             err_framing_q;

    logic xfer;
    logic d_ready_c;
    logic hs_done_c;
    logic accept;
    logic drain_sent;
    logic drain_eop;

    // -----------------------------------------------------------------------
    // Handshake decode. d_ready depends only on state, obuf and tx_ready
    // (plus hs_req in IDLE for handshake priority), never on d_valid.
    // -----------------------------------------------------------------------
    always_comb begin
        xfer      = obuf_q.valid && tx_ready;
        d_ready_c = 1'b0;
        hs_done_c = 1'b0;
        case (state_q)
            ST_IDLE:  d_ready_c = rst_n && !hs_req;
            ST_HS:    hs_done_c = xfer;
            // Accept into an empty register, or reload in the transfer
            // cycle. An empty register with tx_ready pending is an underrun,
            // so no byte is taken then; nothing follows an eop byte.
            ST_DATA:  d_ready_c = !obuf_q.eop &&
                                  (xfer || (!obuf_q.valid && !tx_ready));
            ST_DRAIN: d_ready_c = 1'b1;
            default:  d_ready_c = 1'b0;
        endcase
        accept     = d_valid && d_ready_c;
        // Abort byte gone: either already transferred or going this cycle.
        drain_sent = !obuf_q.valid || xfer;
        drain_eop  = drain_eop_q || (d_valid && d_eop);
    end

    // -----------------------------------------------------------------------
    // Scheduler FSM, byte register and gap counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            obuf_q         <= '0;
            gap_cnt_q      <= '0;
            drain_eop_q    <= 1'b0;
            err_underrun_q <= 1'b0;
            err_framing_q  <= 1'b0;
        end else begin
            err_underrun_q <= 1'b0;
            err_framing_q  <= 1'b0;

            // Default: a transferred byte empties the register; any load
            // below in the same cycle overrides this.
            if (xfer) begin
                obuf_q.valid <= 1'b0;
                obuf_q.sop   <= 1'b0;
                obuf_q.eop   <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (hs_req) begin
                        obuf_q  <= obuf_load(1'b1, 1'b1, hs_pid);
                        state_q <= ST_HS;
                    end else if (d_valid && d_sop) begin
                        obuf_q  <= obuf_load(1'b1, d_eop, d_data);
                        state_q <= ST_DATA;
                    end else if (d_valid) begin
                        err_framing_q <= 1'b1;
                    end
                end

                ST_HS: begin
                    if (xfer) begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= ST_GAP;
                    end
                end

                ST_DATA: begin
                    if (!obuf_q.valid && tx_ready) begin
                        err_underrun_q <= 1'b1;
                        obuf_q         <= obuf_load(1'b0, 1'b1, ABORT_BYTE);
                        drain_eop_q    <= 1'b0;
                        state_q        <= ST_DRAIN;
                    end else begin
                        if (accept) begin
                            obuf_q <= obuf_load(1'b0, d_eop, d_data);
                        end
                        if (xfer && obuf_q.eop) begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= ST_GAP;
                        end
                    end
                end

                // The abort byte transfer and the source's eop may come in
                // either order; leave only once both have happened.
                ST_DRAIN: begin
                    if (drain_sent && drain_eop) begin
                        drain_eop_q <= 1'b0;
                        gap_cnt_q   <= GAP_LOAD;
                        state_q     <= ST_GAP;
                    end else if (d_valid && d_eop) begin
                        drain_eop_q <= 1'b1;
                    end
                end

                // Leaving as the count reaches zero puts IDLE in the cycle
                // IPG_CLKS after the last transfer, so the next tx_sop can
                // appear IPG_CLKS + 1 cycles after it.
                ST_GAP: begin
                    if (gap_cnt_q <= GAP_ONE) begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_ONE;
                    end
                end

                default: begin
                    obuf_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_valid     = obuf_q.valid;
    assign tx_sop       = obuf_q.sop;
    assign tx_eop       = obuf_q.eop;
    assign tx_data      = obuf_q.data;
    assign d_ready      = d_ready_c;
    assign hs_done      = hs_done_c;
    assign busy         = (state_q != ST_IDLE);
    assign err_underrun = err_underrun_q;
    assign err_framing  = err_framing_q;

endmodule

// File: tb/tb_phy_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_phy_tx_sched
//   Bench for phy_tx_sched: directed scenarios plus a randomized phase, all
//   checked every cycle against a transaction-level model of the scheduler.
// ---------------------------------------------------------------------------
module tb_phy_tx_sched;
    import usb_phy_pkg::*;

    localparam int unsigned IPG = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hs_req = 1'b0;
    logic [7:0] hs_pid = 8'h00;
    logic       hs_done;
    logic       d_valid = 1'b0;
    logic       d_sop = 1'b0;
    logic       d_eop = 1'b0;
    logic [7:0] d_data = 8'h00;
    logic       d_ready;
    logic       tx_sop, tx_eop, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       busy, err_underrun, err_framing;

    always #5 clk = ~clk;

    phy_tx_sched #(.IPG_CLKS(IPG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hs_req       (hs_req),
        .hs_pid       (hs_pid),
        .hs_done      (hs_done),
        .d_valid      (d_valid),
        .d_sop        (d_sop),
        .d_eop        (d_eop),
        .d_data       (d_data),
        .d_ready      (d_ready),
        .tx_sop       (tx_sop),
        .tx_eop       (tx_eop),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .err_underrun (err_underrun),
        .err_framing  (err_framing)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Event logs observed on the DUT, used by the directed literal checks.
    typedef struct {
        int unsigned cyc;
        logic        sop;
        logic        eop;
        logic [7:0]  data;
    } wire_t;
    wire_t       xlog[$];
    int unsigned hsd_log[$];
    int unsigned und_log[$];
    int unsigned frm_log[$];
    int unsigned sop_log[$];
    logic        prev_sv = 1'b0;

    // Model: who owns the wire, the byte waiting for the serializer, and
    // the cycle number before which the wire must stay quiet.
    int          m_owner = 0;          // 0 none, 1 handshake, 2 data packet
    bit          m_abort = 0;
    bit          m_have = 0, m_sop = 0, m_eop = 0;
    logic [7:0]  m_data = 8'h00;
    bit          m_eop_got = 0;
    int unsigned m_quiet_until = 0;
    bit          m_pu = 0, m_pf = 0;

    always @(negedge clk) begin
        logic  idle, xf, e_rdy, sent, got, old_eop;
        wire_t w;
        cyc++;
        if (!rst_n) begin
            m_owner = 0; m_abort = 0; m_have = 0; m_sop = 0; m_eop = 0;
            m_eop_got = 0; m_quiet_until = 0; m_pu = 0; m_pf = 0;
            prev_sv = 1'b0;
            check("rst_tx_valid", tx_valid, 0);
            check("rst_tx_sop", tx_sop, 0);
            check("rst_tx_eop", tx_eop, 0);
            check("rst_busy", busy, 0);
            check("rst_d_ready", d_ready, 0);
            check("rst_hs_done", hs_done, 0);
            check("rst_err_underrun", err_underrun, 0);
            check("rst_err_framing", err_framing, 0);
        end else begin
            idle = (m_owner == 0) && (cyc >= m_quiet_until);
            xf   = m_have && tx_ready;
            if (idle)                        e_rdy = !hs_req;
            else if (m_owner == 2 && m_abort) e_rdy = 1'b1;
            else if (m_owner == 2)           e_rdy = m_have ? (tx_ready && !m_eop) : !tx_ready;
            else                             e_rdy = 1'b0;

            check("tx_valid", tx_valid, m_have);
            check("tx_sop", tx_sop, m_have && m_sop);
            check("tx_eop", tx_eop, m_have && m_eop);
            if (m_have) check("tx_data", tx_data, m_data);
            check("busy", busy, !idle);
            check("d_ready", d_ready, e_rdy);
            check("hs_done", hs_done, (m_owner == 1) && xf);
            check("err_underrun", err_underrun, m_pu);
            check("err_framing", err_framing, m_pf);

            if (tx_valid && tx_ready) begin
                w.cyc = cyc; w.sop = tx_sop; w.eop = tx_eop; w.data = tx_data;
                xlog.push_back(w);
            end
            if (hs_done)      hsd_log.push_back(cyc);
            if (err_underrun) und_log.push_back(cyc);
            if (err_framing)  frm_log.push_back(cyc);
            if (tx_valid && tx_sop && !prev_sv) sop_log.push_back(cyc);
            prev_sv = tx_valid && tx_sop;

            // Advance the model across the coming clock edge.
            m_pu = 0; m_pf = 0;
            if (idle) begin
                if (hs_req) begin
                    m_owner = 1; m_have = 1; m_sop = 1; m_eop = 1; m_data = hs_pid;
                end else if (d_valid && d_sop) begin
                    m_owner = 2; m_have = 1; m_sop = 1; m_eop = d_eop; m_data = d_data;
                end else if (d_valid) begin
                    m_pf = 1;
                end
            end else if (m_owner == 1) begin
                if (xf) begin
                    m_owner = 0; m_have = 0; m_quiet_until = cyc + IPG;
                end
            end else if (m_owner == 2 && !m_abort) begin
                if (!m_have && tx_ready) begin
                    m_pu = 1; m_abort = 1; m_eop_got = 0;
                    m_have = 1; m_sop = 0; m_eop = 1; m_data = ABORT_BYTE;
                end else begin
                    old_eop = m_eop;
                    if (xf) begin
                        m_have = 0; m_sop = 0; m_eop = 0;
                        if (old_eop) begin
                            m_owner = 0; m_quiet_until = cyc + IPG;
                        end
                    end
                    if (d_valid && e_rdy) begin
                        m_have = 1; m_sop = 0; m_eop = d_eop; m_data = d_data;
                    end
                end
            end else if (m_owner == 2) begin
                sent = !m_have || xf;
                got  = m_eop_got || (d_valid && d_eop);
                if (xf) m_have = 0;
                if (sent && got) begin
                    m_owner = 0; m_abort = 0; m_eop_got = 0; m_quiet_until = cyc + IPG;
                end else if (d_valid && d_eop) begin
                    m_eop_got = 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xlog.delete(); hsd_log.delete(); und_log.delete();
        frm_log.delete(); sop_log.delete();
    endtask

    task automatic wait_idle();
        int unsigned k = 0;
        @(negedge clk);
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("wait_idle_timeout", busy, 0);
        tick();
    endtask

    // Data source: holds each byte until accepted, optional stall after
    // the byte at index stall_after.
    task automatic src_send(input logic [7:0] b[$], input int unsigned stall_after,
                            input int unsigned stall_len);
        int unsigned k;
        for (int i = 0; i < b.size(); i++) begin
            d_valid = 1'b1;
            d_sop   = (i == 0);
            d_eop   = (i == b.size() - 1);
            d_data  = b[i];
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!d_ready && k < 400);
            if (!d_ready) check("src_accept_timeout", d_ready, 1);
            tick();
            if (i == stall_after) begin
                d_valid = 1'b0;
                repeat (stall_len) tick();
            end
        end
        d_valid = 1'b0; d_sop = 1'b0; d_eop = 1'b0;
    endtask

    // Serializer: periodic single-cycle tx_ready until n_x transfers seen.
    task automatic ser_run(input int unsigned n_x, input int unsigned period,
                           input int unsigned budget);
        int unsigned k = 0;
        while (xlog.size() < n_x && k < budget) begin
            repeat (period - 1) begin
                tick();
                k++;
            end
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            k++;
        end
        if (xlog.size() < n_x) check("ser_xfer_timeout", xlog.size(), n_x);
    endtask

    logic [7:0] pkt[$];
    logic [7:0] e2 [4] = '{8'hC3, 8'h01, 8'h02, 8'h03};
    logic [7:0] pids [3] = '{PID_ACK, PID_NAK, PID_STALL};

    initial begin : watchdog
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin : main
        int unsigned n, k, pos;
        logic hd, acc;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // ---------------- Handshake ----------------
        clear_logs();
        hs_pid = PID_ACK; hs_req = 1'b1;
        tick();
        repeat (31) tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0; hs_req = 1'b0;
        n = 0;
        for (int i = 0; i < 4 * IPG; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("hs_gap_busy_cycles", n, IPG - 1);
        check("hs_xfer_count", xlog.size(), 1);
        if (xlog.size() >= 1) begin
            check("hs_byte", xlog[0].data, 8'hD2);
            check("hs_sop", xlog[0].sop, 1);
            check("hs_eop", xlog[0].eop, 1);
            check("hs_done_count", hsd_log.size(), 1);
            if (hsd_log.size() >= 1) check("hs_done_cycle", hsd_log[0], xlog[0].cyc);
        end
        tick();

        // ---------------- 4-byte data packet ----------------
        wait_idle();
        clear_logs();
        pkt = '{8'hC3, 8'h01, 8'h02, 8'h03};
        fork
            src_send(pkt, 99, 0);
            ser_run(4, 4, 200);
        join
        wait_idle();
        check("pkt4_xfer_count", xlog.size(), 4);
        if (xlog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("pkt4_data", xlog[i].data, e2[i]);
                check("pkt4_sop", xlog[i].sop, (i == 0));
                check("pkt4_eop", xlog[i].eop, (i == 3));
            end
        end
        check("pkt4_no_underrun", und_log.size(), 0);

        // ---------------- Simultaneous requests ----------------
        clear_logs();
        pkt = '{8'hA5, 8'h11};
        fork
            begin
                hs_pid = PID_NAK; hs_req = 1'b1;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!hs_done && k < 400);
                if (!hs_done) check("sim_hs_done_timeout", hs_done, 1);
                tick();
                hs_req = 1'b0;
            end
            src_send(pkt, 99, 0);
            ser_run(3, 3, 300);
        join
        wait_idle();
        check("sim_xfer_count", xlog.size(), 3);
        check("sim_sop_count", sop_log.size(), 2);
        if (xlog.size() == 3 && sop_log.size() == 2) begin
            check("sim_first_is_hs", xlog[0].data, 8'h5A);
            check("sim_data0", xlog[1].data, 8'hA5);
            check("sim_data1_eop", xlog[2].eop, 1);
            check("sim_gap", sop_log[1] - xlog[0].cyc, IPG + 1);
        end

        // ---------------- Underrun ----------------
        clear_logs();
        pkt = '{8'hC3, 8'h10, 8'h20, 8'h30, 8'h40};
        fork
            src_send(pkt, 1, 12);
            ser_run(3, 3, 200);
        join
        wait_idle();
        check("und_count", und_log.size(), 1);
        check("und_xfer_count", xlog.size(), 3);
        if (xlog.size() == 3) begin
            check("und_byte1", xlog[1].data, 8'h10);
            check("und_abort_data", xlog[2].data, 8'hFF);
            check("und_abort_eop", xlog[2].eop, 1);
            check("und_abort_sop", xlog[2].sop, 0);
        end

        // ---------------- Framing error ----------------
        clear_logs();
        d_valid = 1'b1; d_sop = 1'b0; d_eop = 1'b0; d_data = 8'h77;
        @(negedge clk);
        check("frm_d_ready", d_ready, 1);
        check("frm_tx_valid", tx_valid, 0);
        tick();
        d_valid = 1'b0;
        @(negedge clk);
        check("frm_pulse", err_framing, 1);
        check("frm_tx_valid_after", tx_valid, 0);
        check("frm_busy", busy, 0);
        tick();

        // ---------------- Reset mid-DATA ----------------
        wait_idle();
        d_valid = 1'b1; d_sop = 1'b1; d_eop = 1'b0; d_data = 8'hC3;
        tick();
        d_valid = 1'b0; d_sop = 1'b0;
        @(negedge clk);
        check("rstmid_pre_valid", tx_valid, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_tx_valid", tx_valid, 0);
        check("rstmid_tx_sop", tx_sop, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_d_ready", d_ready, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        pkt = '{8'h3C, 8'h4D};
        fork
            src_send(pkt, 99, 0);
            ser_run(2, 3, 200);
        join
        wait_idle();
        check("rstmid_xfer_count", xlog.size(), 2);
        if (xlog.size() == 2) begin
            check("rstmid_new_data", xlog[0].data, 8'h3C);
            check("rstmid_new_sop", xlog[0].sop, 1);
            check("rstmid_new_eop", xlog[1].eop, 1);
        end

        // ---------------- Randomized traffic ----------------
        pos = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hd  = hs_done;
            acc = d_valid && d_ready;
            @(posedge clk);
            #1;
            tx_ready = ($urandom_range(0, 3) == 0);
            if (hs_req && hd) begin
                hs_req = 1'b0;
            end else if (!hs_req && $urandom_range(0, 39) == 0) begin
                hs_req = 1'b1;
                hs_pid = pids[$urandom_range(0, 2)];
            end
            if (acc) pos = d_eop ? 0 : pos + 1;
            if (!d_valid || acc) begin
                d_valid = ($urandom_range(0, 2) != 0);
                d_sop   = (pos == 0) ? ($urandom_range(0, 15) != 0)
                                     : ($urandom_range(0, 15) == 0);
                d_eop   = ($urandom_range(0, 4) == 0);
                d_data  = 8'($urandom);
            end
            if (c == 1500) begin
                rst_n = 1'b0; hs_req = 1'b0; d_valid = 1'b0; pos = 0;
            end else begin
                rst_n = 1'b1;
            end
        end
        hs_req = 1'b0; d_valid = 1'b0; tx_ready = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
